nyq_seq_ctrl: RTL and testbench

- Sequencer for the polyphase Nyquist decimation datapath (NUM_STAGES MAC units feeding a chain of partial-sum registers).
- Generates the per-sample coefficient phase, the MAC enable and clear strobes, the partial-sum shift enable and the decimated output valid strobe.
- Handles start-up priming of the partial-sum chain and freezes the datapath while the parameter memory is being written.
- Sits between the sample source and the NYQ datapath; contains no arithmetic on sample data.

---
 rtl/nyq_seq_ctrl_if.sv | 27 ++
 rtl/nyq_seq_ctrl.sv | 114 +++++++++++
 tb/tb_nyq_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/nyq_seq_ctrl_if.sv
// Control bundle between the sample source and the Nyquist decimation sequencer.
// The master drives run/write/sample requests; the slave returns datapath strobes.
interface nyq_seq_ctrl_if #(
    parameter int CNT_WIDTH = 3
);
    logic                 Enable_SI;
    logic                 WrEn_SI;
    logic [CNT_WIDTH-1:0] DecimM1_DI;
    logic                 InValid_SI;
    logic [CNT_WIDTH-1:0] Phase_DO;
    logic                 MacEn_SO;
    logic                 MacClr_SO;
    logic                 ShiftEn_SO;
    logic                 Valid_DO;
    logic                 Primed_SO;
    logic                 Busy_SO;

    modport master (
        output Enable_SI, WrEn_SI, DecimM1_DI, InValid_SI,
        input  Phase_DO, MacEn_SO, MacClr_SO, ShiftEn_SO, Valid_DO, Primed_SO, Busy_SO
    );

    modport slave (
        input  Enable_SI, WrEn_SI, DecimM1_DI, InValid_SI,
        output Phase_DO, MacEn_SO, MacClr_SO, ShiftEn_SO, Valid_DO, Primed_SO, Busy_SO
    );
endinterface

// File: rtl/nyq_seq_ctrl.sv
// Sequencer for the polyphase Nyquist decimator: coefficient phase, MAC strobes,
// partial-sum shift and decimated-output valid, with chain priming and write abort.
module nyq_seq_ctrl #(
    parameter int CNT_WIDTH  = 3,
    parameter int NUM_STAGES = 4,
    parameter int FCNT_WIDTH = 3
) (
    input  logic               Clk_CI,
    input  logic               Rst_RBI,
    nyq_seq_ctrl_if.slave      Seq_io
);
    typedef enum logic [1:0] {
        Idle = 2'd0,
        Fill = 2'd1,
        Run  = 2'd2
    } state_e;

    localparam logic [FCNT_WIDTH-1:0] FrmFull = FCNT_WIDTH'(NUM_STAGES);
    localparam logic [FCNT_WIDTH-1:0] FrmLast = FCNT_WIDTH'(NUM_STAGES - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  phase_q, phase_d;
    logic [CNT_WIDTH-1:0]  decim_q, decim_d;
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                  shift_q, shift_d;
    logic                  valid_q, valid_d;

    logic startReq, abortReq, accept, frameEnd;

    assign startReq = Seq_io.Enable_SI & ~Seq_io.WrEn_SI;
    assign abortReq = ~Seq_io.Enable_SI | Seq_io.WrEn_SI;
    assign accept   = Seq_io.InValid_SI & (state_q != Idle) & startReq;
    assign frameEnd = accept & (phase_q == decim_q);

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // The chain becomes primed on the same edge that completes the last fill frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle: if (startReq) state_d = Fill;
            Fill: begin
                if (abortReq) begin
                    state_d = Idle;
                end else if (frameEnd && (fcnt_q == FrmLast)) begin
                    state_d = Run;
                end
            end
            Run:  if (abortReq) state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        Seq_io.Phase_DO   = phase_q;
        Seq_io.MacEn_SO   = accept;
        Seq_io.MacClr_SO  = accept & (phase_q == '0);
        Seq_io.ShiftEn_SO = shift_q;
        Seq_io.Valid_DO   = valid_q;
        Seq_io.Primed_SO  = (state_q == Run);
        Seq_io.Busy_SO    = (state_q != Idle);
    end

    // Valid looks at the frame count during the shift cycle, so an abort on that
    // edge still lets an already-registered shift produce its output strobe.
    always_comb begin
        phase_d = phase_q;
        decim_d = decim_q;
        fcnt_d  = fcnt_q;
        shift_d = frameEnd;
        valid_d = shift_q & (fcnt_q == FrmFull);
        if (state_q == Idle) begin
            phase_d = '0;
            fcnt_d  = '0;
            if (startReq) begin
                decim_d = Seq_io.DecimM1_DI;
            end
        end else if (abortReq) begin
            phase_d = '0;
            fcnt_d  = '0;
        end else if (accept) begin
            if (frameEnd) begin
                phase_d = '0;
                if (fcnt_q != FrmFull) begin
                    fcnt_d = fcnt_q + FCNT_WIDTH'(1);
                end
            end else begin
                phase_d = phase_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            phase_q <= '0;
            decim_q <= '0;
            fcnt_q  <= '0;
            shift_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            decim_q <= decim_d;
            fcnt_q  <= fcnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_nyq_seq_ctrl.sv
// Self-checking bench for nyq_seq_ctrl: directed scenarios plus random traffic,
// compared each cycle against a frame/event-schedule reference model.
module tb_nyq_seq_ctrl;
    localparam int CW = 3;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    nyq_seq_ctrl_if #(.CNT_WIDTH(CW)) bus();

    nyq_seq_ctrl #(
        .CNT_WIDTH (CW),
        .NUM_STAGES(NS),
        .FCNT_WIDTH(3)
    ) dut (
        .Clk_CI (clk),
        .Rst_RBI(rstN),
        .Seq_io (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run flag, latched period, position in frame, frames completed,
    // and a small ring of scheduled shift/valid events indexed by cycle number.
    bit mRun;
    int mDecim, mPhase, mFrames, cyc;
    bit shiftSched[8];
    bit validSched[8];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void modelReset();
        mRun    = 1'b0;
        mDecim  = 0;
        mPhase  = 0;
        mFrames = 0;
        for (int i = 0; i < 8; i++) begin
            shiftSched[i] = 1'b0;
            validSched[i] = 1'b0;
        end
    endfunction

    task automatic checkOutput();
        bit acc;
        acc = bus.InValid_SI && mRun && bus.Enable_SI && !bus.WrEn_SI;
        checkVal("Phase",   32'(bus.Phase_DO),   32'(mPhase));
        checkVal("MacEn",   32'(bus.MacEn_SO),   32'(acc));
        checkVal("MacClr",  32'(bus.MacClr_SO),  32'(acc && (mPhase == 0)));
        checkVal("ShiftEn", 32'(bus.ShiftEn_SO), 32'(shiftSched[cyc % 8]));
        checkVal("Valid",   32'(bus.Valid_DO),   32'(validSched[cyc % 8]));
        checkVal("Primed",  32'(bus.Primed_SO),  32'(mRun && (mFrames >= NS)));
        checkVal("Busy",    32'(bus.Busy_SO),    32'(mRun));
    endtask

    // Advance the model across the coming clock edge using the inputs now driven.
    task automatic modelStep();
        bit en, wr, inv;
        en  = bus.Enable_SI;
        wr  = bus.WrEn_SI;
        inv = bus.InValid_SI;
        shiftSched[cyc % 8] = 1'b0;
        validSched[cyc % 8] = 1'b0;
        if (!rstN) begin
            modelReset();
        end else if (!mRun) begin
            if (en && !wr) begin
                mRun    = 1'b1;
                mDecim  = int'(bus.DecimM1_DI);
                mPhase  = 0;
                mFrames = 0;
            end
        end else if (!en || wr) begin
            mRun    = 1'b0;
            mPhase  = 0;
            mFrames = 0;
        end else if (inv) begin
            if (mPhase == mDecim) begin
                mPhase = 0;
                if (mFrames < NS) mFrames++;
                shiftSched[(cyc + 1) % 8] = 1'b1;
                if (mFrames >= NS) validSched[(cyc + 2) % 8] = 1'b1;
            end else begin
                mPhase++;
            end
        end
        cyc++;
    endtask

    task automatic applyStimulus(input bit en, input bit wr, input int dm, input bit inv);
        @(negedge clk);
        bus.Enable_SI  = en;
        bus.WrEn_SI    = wr;
        bus.DecimM1_DI = CW'(dm);
        bus.InValid_SI = inv;
        #1;
        checkOutput();
        modelStep();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int curDm;
        bit reached;
        bus.Enable_SI  = 1'b0;
        bus.WrEn_SI    = 1'b0;
        bus.DecimM1_DI = '0;
        bus.InValid_SI = 1'b0;
        cyc  = 0;
        modelReset();
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1 checkOutput();
        applyStimulus(1, 0, 7, 1);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Continuous input, period 8: priming takes 32 samples.
        for (int i = 0; i < 45; i++) applyStimulus(1, 0, 7, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 7, 0);

        // Alternating input valid: period doubles in wall-clock cycles.
        for (int i = 0; i < 80; i++) applyStimulus(1, 0, 7, (i % 2) == 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

        // Decimation by one: every sample ends a frame.
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 7, 0);

        // Write abort at phase 5 of the third frame, then a full refill.
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            applyStimulus(1, 0, 7, 1);
            reached = (mFrames == 2) && (mPhase == 5);
        end
        checkVal("ReachWrEnPoint", 32'(reached), 32'd1);
        applyStimulus(1, 1, 7, 1);
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 7, 1);

        // Period change is ignored until the next IDLE exit.
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 3, 1);
        applyStimulus(0, 0, 3, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 3, 1);

        // Random traffic with occasional aborts and period changes.
        curDm = 5;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) curDm = int'($urandom_range(0, 7));
            applyStimulus(($urandom % 16) != 0, ($urandom % 32) == 0, curDm, ($urandom % 4) != 0);
        end

        // Asynchronous reset while primed at phase 4.
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 7, 0);
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            applyStimulus(1, 0, 7, 1);
            reached = (mFrames >= NS) && (mPhase == 4);
        end
        checkVal("ReachResetPoint", 32'(reached), 32'd1);
        @(posedge clk);
        #1;
        checkVal("PreResetPhase",  32'(bus.Phase_DO),  32'd4);
        checkVal("PreResetPrimed", 32'(bus.Primed_SO), 32'd1);
        #1 rstN = 1'b0;
        #1;
        modelReset();
        checkOutput();
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 7, 1);
        @(posedge clk);
        #1 rstN = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
